// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out bundle between the stream source, conv_window_gen and CE
interface conv_window_gen_if #(parameter int CL_IN = 2, parameter int KERNEL = 3, parameter int N = 4);
   logic [CL_IN*N-1:0]               d_in;
   logic                             en_in;
   logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv;
   logic                             en_out;
   logic                             last_out;
   modport master (output d_in, en_in, input data2conv, en_out, last_out);
   modport slave (input d_in, en_in, output data2conv, en_out, last_out);
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into stride-1 KERNEL x KERNEL x CL_IN windows for CE
module conv_window_gen #(
   parameter int CL_IN  = 2,
   parameter int KERNEL = 3,
   parameter int N      = 4,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input logic             clk,
   input logic             rst,
   conv_window_gen_if.slave bus
);
   localparam int PW = CL_IN*N;
   localparam int WB = CL_IN*KERNEL*KERNEL*N;
   localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
   localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] new_col [KERNEL];
   logic [PW-1:0] win     [KERNEL][KERNEL];
   logic [PW-1:0] win_nxt [KERNEL][KERNEL];
   logic [WB-1:0] packed_nxt;
   logic          col_end, row_end, fire;
   assign col_end = col == CW'(IMG_W-1);
   assign row_end = row == RW'(IMG_H-1);
   // positions left of/above the first full window never fire, so stale or wrapped data is never emitted
   assign fire = bus.en_in && int'(row) >= KERNEL-1 && int'(col) >= KERNEL-1;
   assign new_col[KERNEL-1] = bus.d_in;
   generate
      if (KERNEL > 1) begin : g_lb
         logic [PW-1:0] lb [KERNEL-1][IMG_W];
         for (genvar g = 0; g < KERNEL-1; g++) begin : g_rd
            assign new_col[g] = lb[g][col];
         end
         // each row buffer takes the column from the next-younger one; the youngest takes d_in
         always_ff @(posedge clk)
            if (bus.en_in)
               for (int i = 0; i < KERNEL-1; i++) lb[i][col] <= new_col[i+1];
      end
   endgenerate
   // shift every window row left and append the fresh column, then lay it out in CE slot order
   always_comb begin
      packed_nxt = '0;
      for (int r = 0; r < KERNEL; r++)
         for (int c = 0; c < KERNEL; c++)
            win_nxt[r][c] = c == KERNEL-1 ? new_col[r] : win[r][(c+1)%KERNEL];
      for (int ch = 0; ch < CL_IN; ch++)
         for (int r = 0; r < KERNEL; r++)
            for (int c = 0; c < KERNEL; c++)
               packed_nxt[(ch*KERNEL*KERNEL+r*KERNEL+c)*N +: N] = win_nxt[r][c][ch*N +: N];
   end
   // window shift array holds between beats
   always_ff @(posedge clk)
      if (bus.en_in) win <= win_nxt;
   // raster counters and registered window output
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col           <= '0;
         row           <= '0;
         bus.en_out    <= 1'b0;
         bus.last_out  <= 1'b0;
         bus.data2conv <= '0;
      end else begin
         bus.en_out   <= fire;
         bus.last_out <= fire && col_end && row_end;
         if (fire) bus.data2conv <= packed_nxt;
         if (bus.en_in) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) row <= row_end ? '0 : row + 1'b1;
         end
      end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized stream against a coordinate-based window model, plus a KERNEL=1 instance
module tb_conv_window_gen;
   localparam int C = 2, K = 3, N = 8, W = 5, H = 4;
   localparam int WB = C*K*K*N;
   localparam int FIRST1[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
   localparam int LAST1[9]  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
   localparam int FIRST2[9] = '{50, 51, 52, 55, 56, 57, 60, 61, 62};
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0, n_pass = 0;
   int mr = 0, mc = 0, n_obs = 0, n_last = 0;
   int img [H][W];
   logic [WB-1:0] wins [$];
   always #5 clk = ~clk;
   conv_window_gen_if #(.CL_IN(C), .KERNEL(K), .N(N)) a_if ();
   conv_window_gen #(.CL_IN(C), .KERNEL(K), .N(N), .IMG_W(W), .IMG_H(H)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   conv_window_gen_if #(.CL_IN(2), .KERNEL(1), .N(4)) b_if ();
   conv_window_gen #(.CL_IN(2), .KERNEL(1), .N(4), .IMG_W(2), .IMG_H(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
   task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [WB-1:0] lit(input int v[9]);
      logic [WB-1:0] w = '0;
      for (int ch = 0; ch < C; ch++)
         for (int s = 0; s < 9; s++) w[(ch*9+s)*N +: N] = 8'(v[s] + 100*ch);
      return w;
   endfunction
   function automatic logic [WB-1:0] model_win(input int pr, input int pc);
      logic [WB-1:0] w = '0;
      for (int ch = 0; ch < C; ch++)
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               w[(ch*K*K+r*K+c)*N +: N] = 8'(img[pr-K+1+r][pc-K+1+c] + 100*ch);
      return w;
   endfunction
   task automatic beat(input bit en, input int v);
      bit exp_fire, exp_last;
      logic [WB-1:0] exp_w;
      a_if.en_in = en;
      a_if.d_in = {8'(v+100), 8'(v)};
      @(posedge clk);
      exp_fire = en && mr >= K-1 && mc >= K-1;
      exp_last = exp_fire && mr == H-1 && mc == W-1;
      exp_w = '0;
      if (en) begin
         img[mr][mc] = v;
         if (exp_fire) exp_w = model_win(mr, mc);
         if (mc == W-1) begin
            mc = 0;
            mr = mr == H-1 ? 0 : mr + 1;
         end else mc++;
      end
      @(negedge clk);
      check("en_out", WB'(a_if.en_out), WB'(exp_fire));
      check("last_out", WB'(a_if.last_out), WB'(exp_last));
      if (exp_fire) check("window", a_if.data2conv, exp_w);
      if (a_if.en_out) begin
         n_obs++;
         wins.push_back(a_if.data2conv);
      end
      if (a_if.last_out) n_last++;
   endtask
   task automatic frame(input int off, input bit stall, input int npix);
      for (int p = 0; p < npix; p++) begin
         while (stall && $urandom_range(1) == 0) beat(1'b0, 0);
         beat(1'b1, (p/W)*5 + p%W + off);
      end
   endtask
   task automatic phase_start();
      n_obs = 0;
      n_last = 0;
      wins.delete();
   endtask
   initial begin
      logic [7:0] bd;
      a_if.en_in = 1'b0;
      a_if.d_in = '0;
      b_if.en_in = 1'b0;
      b_if.d_in = '0;
      repeat (2) @(negedge clk);
      check("rst_en_out", WB'(a_if.en_out), '0);
      check("rst_data", a_if.data2conv, '0);
      check("rst_last", WB'(a_if.last_out), '0);
      rst = 1'b0;
      phase_start();
      frame(0, 1'b0, W*H);
      beat(1'b0, 0);
      check("basic_count", WB'(n_obs), WB'(6));
      check("basic_last_count", WB'(n_last), WB'(1));
      if (wins.size() == 6) begin
         check("basic_first", wins[0], lit(FIRST1));
         check("basic_sixth", wins[5], lit(LAST1));
      end else check("basic_queue", WB'(wins.size()), WB'(6));
      phase_start();
      frame(0, 1'b1, W*H);
      beat(1'b0, 0);
      check("stall_count", WB'(n_obs), WB'(6));
      phase_start();
      frame(0, 1'b0, W*H);
      frame(50, 1'b0, W*H);
      beat(1'b0, 0);
      check("b2b_count", WB'(n_obs), WB'(12));
      check("b2b_last_count", WB'(n_last), WB'(2));
      if (wins.size() == 12) check("b2b_f2_first", wins[6], lit(FIRST2));
      else check("b2b_queue", WB'(wins.size()), WB'(12));
      frame(0, 1'b0, 9);
      rst = 1'b1;
      #1;
      check("midrst_en_out", WB'(a_if.en_out), '0);
      check("midrst_data", a_if.data2conv, '0);
      @(negedge clk);
      check("midrst_hold_en", WB'(a_if.en_out), '0);
      rst = 1'b0;
      mr = 0;
      mc = 0;
      phase_start();
      frame(30, 1'b1, W*H);
      beat(1'b0, 0);
      check("midrst_count", WB'(n_obs), WB'(6));
      check("midrst_last_count", WB'(n_last), WB'(1));
      for (int p = 0; p < 4; p++) begin
         bd = 8'($urandom);
         b_if.en_in = 1'b1;
         b_if.d_in = bd;
         @(posedge clk);
         @(negedge clk);
         b_if.en_in = 1'b0;
         check("k1_en_out", WB'(b_if.en_out), WB'(1));
         check("k1_data", WB'(b_if.data2conv), WB'(bd));
         check("k1_last", WB'(b_if.last_out), WB'(p == 3));
      end
      @(negedge clk);
      check("k1_idle", WB'(b_if.en_out), '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
